// File: rtl/mc_controller.sv
// mc_controller
//   Multicycle control sequencer for a non-pipelined MIPS core sharing one
//   instruction/data memory. A Moore FSM walks each instruction through
//   fetch, decode, execute, memory and writeback. The machine waits in the
//   memory states until the memory acknowledges with mem_ready.
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   FETCH    | read instr at PC; on ack load IR and advance PC to PC+4
//   DECODE   | precompute branch target into ALUOut, dispatch on opcode
//   MEMADR   | compute load/store address (A + signext imm)
//   MEMRD    | read data memory at ALUOut, wait for ack
//   MEMWB    | write loaded word/byte to rt
//   MEMWR    | write regB to memory at ALUOut, wait for ack
//   RTYPEEX  | ALU op on A and B per funct
//   RTYPEWB  | write ALUOut to rd
//   BRANCHEX | compare A and B, conditional PC load with branch target
//   ADDIEX   | A + signext imm
//   ADDIWB   | write ALUOut to rt
//   JEX      | PC <- jump target
//   JALEX    | PC <- jump target, $31 <- PC (already PC+4)
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   op              opcode from IR, valid from DECODE onward
//   mem_ready       memory acknowledge for the current request
//   memread/memwrite/iord          memory request and address select
//   irwrite/pcwrite/branch/bne/pcsrc  IR and PC update controls
//   alusrca/alusrcb/aluop          ALU operand and operation selects
//   regwrite/regdst/memtoreg/lb    register file writeback controls
//   instr_done      pulse on the last cycle of every instruction
//   illegal_op      pulse in DECODE on an unsupported opcode

module mc_controller #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           memread,
  output logic           memwrite,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           branch,
  output logic           bne,
  output logic [1:0]     pcsrc,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic           regwrite,
  output logic [1:0]     regdst,
  output logic [1:0]     memtoreg,
  output logic           lb,
  output logic           instr_done,
  output logic           illegal_op
);

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_LB    = 6'b100000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_JAL   = 6'b000011;

  typedef enum logic [STW-1:0] {
    S_FETCH    = STW'(0),
    S_DECODE   = STW'(1),
    S_MEMADR   = STW'(2),
    S_MEMRD    = STW'(3),
    S_MEMWB    = STW'(4),
    S_MEMWR    = STW'(5),
    S_RTYPEEX  = STW'(6),
    S_RTYPEWB  = STW'(7),
    S_BRANCHEX = STW'(8),
    S_ADDIEX   = STW'(9),
    S_ADDIWB   = STW'(10),
    S_JEX      = STW'(11),
    S_JALEX    = STW'(12)
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    lb         = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // IR load and PC+4 commit only on the acknowledge cycle
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:         state_d = S_RTYPEEX;
          OP_LW, OP_SW,
          OP_LB:            state_d = S_MEMADR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCHEX;
          OP_ADDI:          state_d = S_ADDIEX;
          OP_J:             state_d = S_JEX;
          OP_JAL:           state_d = S_JALEX;
          default: begin
            // unsupported opcodes retire here as a no-op
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 2'b01;
        lb         = (op == OP_LB);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regwrite   = 1'b1;
        regdst     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCHEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = (op == OP_BEQ);
        bne        = (op == OP_BNE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JEX: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JALEX: begin
        // PC was advanced in FETCH, so memtoreg=10 writes the return address
        regwrite   = 1'b1;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // reset abandons the instruction: no strobes in the reset cycle
    if (reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      bne        = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      regwrite   = 1'b0;
      regdst     = 2'b00;
      memtoreg   = 2'b00;
      lb         = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control sequencer for the MIPS core in a shared-memory, non-pipelined build.
- Replaces the single-cycle opcode decoder with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback.
- Drives PC, IR, register-file, ALU-mux and memory enables.
- Holds in memory states until the unified instruction/data memory acknowledges with mem_ready.
- Supports R-type, LW, SW, BEQ, BNE, ADDI, J, JAL, LB.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width (13 states used).

Ports:
- clk in 1 system clock
- reset in 1 synchronous, active-high reset
- op in 6 opcode from the IR (instr[31:26]); valid from DECODE onward
- mem_ready in 1 memory acknowledge for the current read or write request
- memread out 1 memory read request
- memwrite out 1 memory write request
- iord out 1 address mux select: 0 = PC, 1 = ALUOut
- irwrite out 1 instruction register load
- pcwrite out 1 unconditional PC load
- branch out 1 PC load if ALU zero (BEQ)
- bne out 1 PC load if ALU not zero (BNE)
- pcsrc out 2 next-PC select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alusrca out 1 ALU A select: 0 = PC, 1 = register A
- alusrcb out 2 ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- aluop out 2 to the ALU decoder: 00 = add, 01 = sub, 10 = funct
- regwrite out 1 register file write enable
- regdst out 2 write register select: 00 = rt, 01 = rd, 10 = $31
- memtoreg out 2 writeback select: 00 = ALUOut, 01 = memory data, 10 = PC
- lb out 1 byte-load sign-extend select during writeback
- instr_done out 1 one-cycle pulse on the last cycle of every instruction
- illegal_op out 1 one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- State register updates on posedge clk. Reset sets state to FETCH on the next edge.
- While reset is high, every output is forced to 0, including multi-bit outputs.
- Reset mid-instruction abandons the instruction; no write strobe is asserted in the reset cycle.
- Unlisted outputs are 0 in each state. Moore outputs, except strobes gated by mem_ready as noted.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - If mem_ready, go to DECODE; else stay.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by op:
    - 000000 -> RTYPEEX
    - 100011, 101011, 100000 -> MEMADR
    - 000100, 000101 -> BRANCHEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - 000011 -> JALEX
    - other -> FETCH with illegal_op=1 and instr_done=1
- MEMADR:
  - alusrca=1, alusrcb=10, aluop=00.
  - SW -> MEMWR; LW or LB -> MEMRD.
- MEMRD:
  - memread=1, iord=1.
  - If mem_ready, go to MEMWB; else stay.
- MEMWB:
  - regwrite=1, regdst=00, memtoreg=01, lb=(op==100000), instr_done=1.
  - Go to FETCH.
- MEMWR:
  - memwrite=1, iord=1; instr_done=mem_ready.
  - If mem_ready, go to FETCH; else stay, holding memwrite high.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Go to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00, instr_done=1. Go to FETCH.
- BRANCHEX:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - branch=(op==000100), bne=(op==000101), instr_done=1.
  - Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=00, memtoreg=00, instr_done=1. Go to FETCH.
- JEX: pcwrite=1, pcsrc=10, instr_done=1. Go to FETCH.
- JALEX:
  - regwrite=1, regdst=10, memtoreg=10 (PC already holds PC+4), pcwrite=1, pcsrc=10, instr_done=1.
  - Go to FETCH.
- Latency with zero-wait memory (mem_ready held at 1), in cycles: R-type 4, LW 5, LB 5, SW 4, BEQ/BNE 3, ADDI 4, J 3, JAL 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready outside those three states is ignored.
- memread and memwrite are never asserted in the same cycle.
- Unused state encodings go to FETCH on the next edge with all outputs 0.
- Implementation: one-hot or binary encoding, free choice within STW bits.

Test Plan:
- Reset then R-type (op=000000), mem_ready=1 -> states FETCH, DECODE, RTYPEEX, RTYPEWB. In cycle 4: regwrite=1, regdst=01, instr_done=1. Cycle 5 back in FETCH.
- LW with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> total 10 cycles. irwrite pulses exactly once. regwrite=1 with memtoreg=01 and lb=0 only in the final cycle.
- SW with mem_ready low 4 cycles in MEMWR -> memwrite held 5 cycles, iord=1 throughout. instr_done only on the acknowledge cycle. regwrite never asserted.
- BEQ then BNE, then JAL -> BRANCHEX has branch=1/bne=0, then branch=0/bne=1, aluop=01, pcsrc=01. JALEX asserts regwrite, regdst=10, memtoreg=10, pcwrite, pcsrc=10 in the same cycle.
- op=111111 -> illegal_op=1 and instr_done=1 in DECODE, no regwrite/memwrite/pcwrite, back in FETCH next cycle. LB (op=100000) -> lb=1 only in MEMWB.
- Assert reset during MEMWR with mem_ready=0 -> all outputs 0 in that cycle. FETCH with memread=1 on the first cycle after reset deasserts. No memwrite after the reset edge.
